// File: rtl/spi_count_readout.sv
// SPI responder that snapshots the per-channel MPPC counters at frame start and
// shifts them to the Pi after a header byte; optionally requests a counter clear.
module spi_count_readout #(
    parameter int NCH = 8,
    parameter int CW  = 10
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              gpioSS,
    input  logic              gpioSCK,
    input  logic              gpioSDI,
    output logic              gpioSDO,
    input  logic [NCH*CW-1:0] chCounts,
    output logic              clearReq,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    localparam int TXW = NCH * CW;
    localparam int BCW = $clog2(TXW + 1);
    localparam logic [7:0] HEADER         = 8'hA5;
    localparam logic [7:0] CMD_READ       = 8'h01;
    localparam logic [7:0] CMD_READ_CLEAR = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAD  = 2'd3
    } state_e;

    logic           ss_s1_q, ss_s2_q, ss_s3_q;
    logic           sck_s1_q, sck_s2_q, sck_s3_q;
    logic           sdi_s1_q, sdi_s2_q;
    logic [1:0]     settle_q, settle_d;
    logic           armed_q, armed_d;
    state_e         state_q, state_d;
    logic [TXW-1:0] shadow_q, shadow_d;
    logic [TXW-1:0] tx_q, tx_d;
    logic [TXW-1:0] tx_load;
    logic [7:0]     cmd_q, cmd_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic           done_q, done_d;
    logic           sdo_q, sdo_d;
    logic           clear_q, clear_d;
    logic           busy_q, busy_d;

    logic ss_fall, ss_rise, sck_rise, sck_fall;

    assign ss_fall  = ~ss_s2_q & ss_s3_q;
    assign ss_rise  = ss_s2_q & ~ss_s3_q;
    assign sck_rise = sck_s2_q & ~sck_s3_q;
    assign sck_fall = ~sck_s2_q & sck_s3_q;

    // Channel 0 goes out first, so it occupies the top of the TX register.
    always_comb begin
        tx_load = '0;
        for (int k = 0; k < NCH; k++) begin
            tx_load[(NCH-1-k)*CW +: CW] = shadow_q[k*CW +: CW];
        end
    end

    always_comb begin
        settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        // A fall is only trusted once SS has been seen high on real pin samples
        // after reset; an SS still held low across reset must not start a frame.
        armed_d   = armed_q | ((settle_q == 2'd3) & ss_s2_q);
        state_d   = state_q;
        shadow_d  = shadow_q;
        tx_d      = tx_q;
        cmd_d     = cmd_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        clear_d   = 1'b0;

        if (ss_rise && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            clear_d = (cmd_q == CMD_READ_CLEAR) && done_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_d     = '0;
                    done_d    = 1'b0;
                    bit_cnt_d = '0;
                    if (ss_fall && armed_q) begin
                        shadow_d            = chCounts;
                        tx_d                = '0;
                        tx_d[TXW-1 -: 8]    = HEADER;
                        state_d             = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        cmd_d = {cmd_q[6:0], sdi_s2_q};
                    end
                    if (sck_fall) begin
                        if (bit_cnt_q == BCW'(7)) begin
                            bit_cnt_d = '0;
                            if (cmd_q == CMD_READ || cmd_q == CMD_READ_CLEAR) begin
                                tx_d    = tx_load;
                                state_d = ST_DATA;
                            end else begin
                                tx_d    = '0;
                                state_d = ST_PAD;
                            end
                        end else begin
                            tx_d      = tx_q << 1;
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_fall) begin
                        tx_d = tx_q << 1;
                        if (bit_cnt_q == BCW'(TXW - 1)) begin
                            done_d    = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = ST_PAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_PAD;
                end
            endcase
        end

        sdo_d  = (state_d != ST_IDLE) ? tx_d[TXW-1] : 1'b0;
        busy_d = armed_q & ~ss_s2_q;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_s3_q   <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            sdi_s1_q  <= 1'b0;
            sdi_s2_q  <= 1'b0;
            settle_q  <= 2'd0;
            armed_q   <= 1'b0;
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            tx_q      <= '0;
            cmd_q     <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            sdo_q     <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ss_s1_q   <= gpioSS;
            ss_s2_q   <= ss_s1_q;
            ss_s3_q   <= ss_s2_q;
            sck_s1_q  <= gpioSCK;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            sdi_s1_q  <= gpioSDI;
            sdi_s2_q  <= sdi_s1_q;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            tx_q      <= tx_d;
            cmd_q     <= cmd_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            sdo_q     <= sdo_d;
            clear_q   <= clear_d;
            busy_q    <= busy_d;
        end
    end

    assign gpioSDO   = sdo_q;
    assign clearReq  = clear_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
endmodule
